mem_bus_arbiter: RTL and testbench

//  Shares one SRAM-like memory bus (req/addr_ok/data_ok) between the fetch

---
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one SRAM-like bus between the fetch port and the load/store port, routing responses back in order.
// Latency: requests and accepts pass through combinationally; each response beat is routed to its requester in the same cycle.
// Backpressure: the grant is locked until bus_addr_ok, and bus_req is held low while MAX_OUTST transactions are outstanding.
module mem_bus_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [2:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int IW = $clog2(MAX_OUTST);
    localparam int PW = IW + 1;
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    logic          lock_vld;
    logic          lock_src;
    logic          grant_vld;
    logic          grant_src;
    logic          grant_req;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          src_mem [MAX_OUTST];
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head_src;

    // Pick the owner of the bus: a held lock wins, otherwise data beats fetch.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_INST;
        if (lock_vld) begin
            grant_vld = 1'b1;
            grant_src = lock_src;
        end else if (data_req) begin
            grant_vld = 1'b1;
            grant_src = SRC_DATA;
        end else if (inst_req) begin
            grant_vld = 1'b1;
            grant_src = SRC_INST;
        end
    end

    assign grant_req = grant_vld && ((grant_src == SRC_DATA) ? data_req : inst_req);

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PW'(MAX_OUTST));
    assign empty = (wr_ptr == rd_ptr);

    // A full tracker blocks new requests even if a response pops this cycle.
    assign bus_req = grant_req && !full && resetn;

    // Route the granted port's fields onto the bus; fetches are always word reads.
    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 3'd2;
        bus_wstrb = 4'h0;
        bus_addr  = inst_addr;
        bus_wdata = 32'h0;
        if (grant_src == SRC_DATA) begin
            bus_wr    = data_wr;
            bus_size  = data_size;
            bus_wstrb = data_wstrb;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
        end
    end

    assign push         = bus_req && bus_addr_ok;
    assign inst_addr_ok = push && (grant_src == SRC_INST);
    assign data_addr_ok = push && (grant_src == SRC_DATA);

    // The head entry is read before any push this cycle, so a stray beat on an
    // empty tracker is dropped rather than matched to a brand-new request.
    assign head_src     = src_mem[rd_ptr[IW-1:0]];
    assign pop          = bus_data_ok && !empty && resetn;
    assign inst_data_ok = pop && (head_src == SRC_INST);
    assign data_data_ok = pop && (head_src == SRC_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    // Hold the grant on the current owner until the bus accepts its request.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld <= 1'b0;
            lock_src <= SRC_INST;
        end else if (bus_req) begin
            if (bus_addr_ok) begin
                lock_vld <= 1'b0;
            end else begin
                lock_vld <= 1'b1;
                lock_src <= grant_src;
            end
        end
    end

    // Advance the tracker pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Record which requester owns each accepted transaction.
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr[IW-1:0]] <= grant_src;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int MAX_OUTST = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [2:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [2:0] ds,
                         input logic [3:0] dst, input logic [31:0] da, input logic [31:0] dwd,
                         input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        inst_req    = ir;
        inst_addr   = ia;
        data_req    = dr;
        data_wr     = dw;
        data_size   = ds;
        data_wstrb  = dst;
        data_addr   = da;
        data_wdata  = dwd;
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rd;
        #2;
    endtask

    task automatic idle(input logic dok, input logic [31:0] rd);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 32'h0, 1'b0, dok, rd);
    endtask

    task automatic inst_cyc(input logic [31:0] ia, input logic aok, input logic dok, input logic [31:0] rd);
        drive(1'b1, ia, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 32'h0, aok, dok, rd);
    endtask

    task automatic data_cyc(input logic [31:0] da, input logic aok, input logic dok, input logic [31:0] rd);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'd2, 4'h0, da, 32'h0, aok, dok, rd);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b1, 32'h1000, 1'b1, 1'b1, 3'd2, 4'hf, 32'h2000, 32'h1, 1'b1, 1'b1, 32'h5);
        checks++;
        if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin
            errors++; $display("FAIL reset_addr_ok got %b want 00", {inst_addr_ok, data_addr_ok});
        end
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL reset_data_ok got %b want 00", {inst_data_ok, data_data_ok});
        end
        idle(1'b0, 32'h0);
        resetn = 1'b1;
        idle(1'b1, 32'h7);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL reset_empty_beat got %b want 00", {inst_data_ok, data_data_ok});
        end
    endtask

    task automatic test_fetch();
        inst_cyc(32'hbfc00000, 1'b1, 1'b0, 32'h0);
        checks++;
        if ({bus_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin
            errors++; $display("FAIL t1_accept got %b want 110", {bus_req, inst_addr_ok, data_addr_ok});
        end
        checks++;
        if ({bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata} !== {32'hbfc00000, 1'b0, 3'd2, 4'h0, 32'h0}) begin
            errors++; $display("FAIL t1_fields addr %h wr %b size %0d wstrb %h wdata %h", bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata);
        end
        idle(1'b1, 32'h24010001);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h24010001) begin
            errors++; $display("FAIL t1_resp ok %b rdata %h want 10 24010001", {inst_data_ok, data_data_ok}, inst_rdata);
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 32'hbfc00004, 1'b1, 1'b1, 3'd2, 4'hf, 32'h80001000, 32'hdeadbeef, 1'b1, 1'b0, 32'h0);
        checks++;
        if ({bus_wr, bus_addr, bus_wdata, bus_wstrb, bus_size} !== {1'b1, 32'h80001000, 32'hdeadbeef, 4'hf, 3'd2}) begin
            errors++; $display("FAIL t2_fields wr %b addr %h wdata %h wstrb %h size %0d", bus_wr, bus_addr, bus_wdata, bus_wstrb, bus_size);
        end
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL t2_data_first got %b want 10", {data_addr_ok, inst_addr_ok});
        end
        inst_cyc(32'hbfc00004, 1'b1, 1'b0, 32'h0);
        checks++;
        if ({inst_addr_ok, bus_wr} !== 2'b10 || bus_addr !== 32'hbfc00004) begin
            errors++; $display("FAIL t2_inst_next ok/wr %b addr %h", {inst_addr_ok, bus_wr}, bus_addr);
        end
        idle(1'b1, 32'h0);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL t2_resp0 got %b want 01", {inst_data_ok, data_data_ok});
        end
        idle(1'b1, 32'h0);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL t2_resp1 got %b want 10", {inst_data_ok, data_data_ok});
        end
    endtask

    task automatic test_lock();
        inst_cyc(32'hbfc00100, 1'b0, 1'b0, 32'h0);
        inst_cyc(32'hbfc00100, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'hbfc00100, 1'b1, 1'b0, 3'd2, 4'h0, 32'h80002000, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'hbfc00100 || data_addr_ok !== 1'b0) begin
            errors++; $display("FAIL t3_locked req %b addr %h dok %b", bus_req, bus_addr, data_addr_ok);
        end
        drive(1'b1, 32'hbfc00100, 1'b1, 1'b0, 3'd2, 4'h0, 32'h80002000, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || bus_addr !== 32'hbfc00100) begin
            errors++; $display("FAIL t3_inst_accept ok %b addr %h", {inst_addr_ok, data_addr_ok}, bus_addr);
        end
        data_cyc(32'h80002000, 1'b1, 1'b0, 32'h0);
        checks++;
        if (data_addr_ok !== 1'b1 || bus_addr !== 32'h80002000) begin
            errors++; $display("FAIL t3_data_after ok %b addr %h", data_addr_ok, bus_addr);
        end
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);
    endtask

    task automatic test_full();
        inst_cyc(32'h100, 1'b1, 1'b0, 32'h0);
        data_cyc(32'h200, 1'b1, 1'b0, 32'h0);
        inst_cyc(32'h104, 1'b1, 1'b0, 32'h0);
        data_cyc(32'h204, 1'b1, 1'b0, 32'h0);
        inst_cyc(32'h108, 1'b1, 1'b0, 32'h0);
        checks++;
        if ({bus_req, inst_addr_ok} !== 2'b00) begin
            errors++; $display("FAIL t4_full_block got %b want 00", {bus_req, inst_addr_ok});
        end
        inst_cyc(32'h108, 1'b1, 1'b1, 32'h11);
        checks++;
        if ({inst_data_ok, data_data_ok, bus_req, inst_addr_ok} !== 4'b1000) begin
            errors++; $display("FAIL t4_pop_while_full got %b want 1000", {inst_data_ok, data_data_ok, bus_req, inst_addr_ok});
        end
        inst_cyc(32'h108, 1'b0, 1'b1, 32'h22);
        checks++;
        if ({inst_data_ok, data_data_ok, bus_req} !== 3'b011 || data_rdata !== 32'h22) begin
            errors++; $display("FAIL t4_resp1_reassert got %b rdata %h", {inst_data_ok, data_data_ok, bus_req}, data_rdata);
        end
        inst_cyc(32'h108, 1'b0, 1'b1, 32'h33);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL t4_resp2 got %b want 10", {inst_data_ok, data_data_ok});
        end
        inst_cyc(32'h108, 1'b1, 1'b1, 32'h44);
        checks++;
        if ({inst_data_ok, data_data_ok, inst_addr_ok} !== 3'b011) begin
            errors++; $display("FAIL t4_resp3 got %b want 011", {inst_data_ok, data_data_ok, inst_addr_ok});
        end
        idle(1'b1, 32'h55);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL t4_resp4 got %b want 10", {inst_data_ok, data_data_ok});
        end
    endtask

    task automatic test_reset_flush();
        inst_cyc(32'h300, 1'b1, 1'b0, 32'h0);
        data_cyc(32'h400, 1'b1, 1'b0, 32'h0);
        apply_reset();
        idle(1'b1, 32'h0);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL t5_flushed_beat got %b want 00", {inst_data_ok, data_data_ok});
        end
        data_cyc(32'h404, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 32'h66);
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL t5_after_reset got %b want 01", {inst_data_ok, data_data_ok});
        end
    endtask

    task automatic test_back_to_back();
        inst_cyc(32'h500, 1'b1, 1'b0, 32'h0);
        data_cyc(32'h600, 1'b1, 1'b0, 32'h0);
        inst_cyc(32'h504, 1'b1, 1'b1, 32'h0);
        checks++;
        if ({inst_data_ok, inst_addr_ok} !== 2'b11) begin
            errors++; $display("FAIL t6_push_pop got %b want 11", {inst_data_ok, inst_addr_ok});
        end
        data_cyc(32'h604, 1'b1, 1'b0, 32'h0);
        inst_cyc(32'h508, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++; $display("FAIL t6_count_two got %b want 1", inst_addr_ok);
        end
        inst_cyc(32'h50c, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL t6_full_after got %b want 0", bus_req);
        end
        // Expected drain order: D, I, D, I
        for (int k = 0; k < 4; k++) begin
            idle(1'b1, 32'h0);
            checks++;
            if ({inst_data_ok, data_data_ok} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL t6_order beat %0d got %b", k, {inst_data_ok, data_data_ok});
            end
        end
    endtask

    // Random traffic against a queue-based reference of outstanding owners.
    task automatic test_random();
        bit          exp_q[$];
        bit          i_pend = 0;
        bit          d_pend = 0;
        bit          locked = 0;
        bit          owner = 0;
        logic [31:0] i_a = 0;
        logic [31:0] d_a = 0;
        logic [31:0] d_wd = 0;
        logic        d_w = 0;
        logic [2:0]  d_s = 0;
        logic [3:0]  d_st = 0;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        bit          has_src;
        bit          src;
        bit          exp_req;
        bit          exp_pop;
        int          done = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1; i_a = {$urandom} & 32'hffff_fffc;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_a = $urandom; d_wd = $urandom; d_w = 1'($urandom_range(0, 1));
                d_s = 3'($urandom_range(0, 2)); d_st = 4'($urandom);
            end
            aok = 1'($urandom_range(0, 1));
            dok = ($urandom_range(0, 2) == 0);
            rd  = $urandom;
            drive(i_pend, i_a, d_pend, d_w, d_s, d_st, d_a, d_wd, aok, dok, rd);

            has_src = locked || i_pend || d_pend;
            src     = locked ? owner : (d_pend ? 1'b1 : 1'b0);
            exp_req = has_src && (exp_q.size() < MAX_OUTST);
            exp_pop = dok && (exp_q.size() > 0);

            checks++;
            if (bus_req !== exp_req) begin
                errors++; $display("FAIL rnd_bus_req cyc %0d got %b want %b", cyc, bus_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (src && {bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata} !== {d_a, d_w, d_s, d_st, d_wd}) begin
                    errors++; $display("FAIL rnd_data_fields cyc %0d addr %h want %h", cyc, bus_addr, d_a);
                end else if (!src && {bus_addr, bus_wr, bus_size} !== {i_a, 1'b0, 3'd2}) begin
                    errors++; $display("FAIL rnd_inst_fields cyc %0d addr %h want %h", cyc, bus_addr, i_a);
                end
            end
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {exp_req && aok && !src, exp_req && aok && src}) begin
                errors++; $display("FAIL rnd_addr_ok cyc %0d got %b", cyc, {inst_addr_ok, data_addr_ok});
            end
            checks++;
            if ({inst_data_ok, data_data_ok} !== {exp_pop && !exp_q[0], exp_pop && exp_q[0]}) begin
                errors++; $display("FAIL rnd_data_ok cyc %0d got %b", cyc, {inst_data_ok, data_data_ok});
            end
            if (exp_pop) begin
                checks++;
                if (inst_rdata !== rd || data_rdata !== rd) begin
                    errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h want %h", cyc, inst_rdata, data_rdata, rd);
                end
                void'(exp_q.pop_front());
                done++;
            end
            if (exp_req && aok) begin
                exp_q.push_back(src);
                locked = 0;
                if (src) d_pend = 0; else i_pend = 0;
            end else if (exp_req) begin
                locked = 1;
                owner  = src;
            end
        end
        checks++;
        if (done < 10) begin
            errors++; $display("FAIL rnd_progress completed %0d want >= 10", done);
        end
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
        data_wstrb = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        test_reset();
        test_fetch();
        test_priority();
        test_lock();
        test_full();
        test_reset_flush();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
